// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port among NPORTS requesters.
// Port 0 (video) has fixed priority, capped at MAXRUN back-to-back grants while
// others wait; ports 1..NPORTS-1 rotate round-robin. One transaction in flight.
module sdram_port_arbiter #(
   parameter int NPORTS  = 3,
   parameter int AW      = 24,
   parameter int MAXRUN  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORTS-1:0]    req,
   input  logic [NPORTS-1:0]    we,
   input  logic [NPORTS*AW-1:0] addr,
   input  logic [NPORTS*16-1:0] wdata,
   input  logic [NPORTS*2-1:0]  bytesel,
   output logic [NPORTS-1:0]    ack,
   output logic [15:0]          rdata,
   output logic                 ctrl_req,
   output logic                 ctrl_we,
   output logic [AW-1:0]        ctrl_addr,
   output logic [15:0]          ctrl_wdata,
   output logic [1:0]           ctrl_bytesel,
   input  logic                 ctrl_ack,
   input  logic                 ctrl_done,
   input  logic [15:0]          ctrl_rdata,
   output logic                 timeout_err
);

   localparam int PW = (NPORTS > 2) ? $clog2(NPORTS) : 1;
   localparam int RW = (MAXRUN > 0) ? $clog2(MAXRUN + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state;
   logic [PW-1:0] grant;
   logic [PW-1:0] rr_ptr;
   logic [RW-1:0] run;
   logic [7:0]    wcnt;

   logic [PW-1:0] pick;
   logic [PW-1:0] cand;
   logic          pick_vld;
   logic          others;
   int            idx;

   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [15:0]   sel_wdata;
   logic [1:0]    sel_bytesel;

   // Grant choice; no decision in an ack cycle so the acked port is never re-picked
   always_comb begin
      others   = |req[NPORTS-1:1];
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      cand     = '0;
      if (ack == '0 && req != '0) begin
         if (req[0] && ((int'(run) < MAXRUN) || !others)) begin
            pick_vld = 1'b1;
         end else begin
            for (int k = 0; k < NPORTS - 1; k++) begin
               idx = int'(rr_ptr) + k;
               if (idx >= NPORTS) idx = idx - (NPORTS - 1);
               cand = PW'(idx);
               if (!pick_vld && req[cand]) begin
                  pick     = cand;
                  pick_vld = 1'b1;
               end
            end
         end
      end
   end

   // Operand mux for the chosen port
   always_comb begin
      sel_we      = 1'b0;
      sel_addr    = '0;
      sel_wdata   = '0;
      sel_bytesel = 2'b11;
      for (int i = 0; i < NPORTS; i++) begin
         if (PW'(i) == pick) begin
            sel_we      = we[i];
            sel_addr    = addr[i*AW +: AW];
            sel_wdata   = wdata[i*16 +: 16];
            sel_bytesel = bytesel[i*2 +: 2];
         end
      end
   end

   // Transaction FSM: IDLE picks a port, ISSUE holds ctrl_req, WAIT awaits done/timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         grant        <= '0;
         ack          <= '0;
         rdata        <= '0;
         ctrl_req     <= 1'b0;
         ctrl_we      <= 1'b0;
         ctrl_addr    <= '0;
         ctrl_wdata   <= '0;
         ctrl_bytesel <= 2'b11;
         timeout_err  <= 1'b0;
         rr_ptr       <= PW'(1);
         run          <= '0;
         wcnt         <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant        <= pick;
                  ctrl_req     <= 1'b1;
                  ctrl_we      <= sel_we;
                  ctrl_addr    <= sel_addr;
                  ctrl_wdata   <= sel_wdata;
                  ctrl_bytesel <= sel_bytesel;
                  if (pick == '0) begin
                     // run only counts while someone else is actually being held off
                     if (!others)                   run <= '0;
                     else if (int'(run) < MAXRUN)   run <= run + 1'b1;
                  end else begin
                     run    <= '0;
                     rr_ptr <= (int'(pick) == NPORTS - 1) ? PW'(1) : pick + 1'b1;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (ctrl_ack) begin
                  ctrl_req <= 1'b0;
                  wcnt     <= '0;
                  if (ctrl_done) begin
                     ack[grant] <= 1'b1;
                     if (!ctrl_we) rdata <= ctrl_rdata;
                     state <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (ctrl_done) begin
                  ack[grant] <= 1'b1;
                  if (!ctrl_we) rdata <= ctrl_rdata;
                  state <= IDLE;
               end else if (int'(wcnt) >= TIMEOUT - 1) begin
                  // force completion so the requester is not stuck forever
                  ack[grant]  <= 1'b1;
                  rdata       <= '0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed requester/controller scenarios, a
// transaction-level reference model compared every cycle, plus literal checks.
module tb_sdram_port_arbiter;

   localparam int NP      = 3;
   localparam int AW      = 24;
   localparam int MAXRUN  = 4;
   localparam int TIMEOUT = 255;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NP-1:0]     req = '0;
   logic [NP-1:0]     we = '0;
   logic [NP*AW-1:0]  addr = '0;
   logic [NP*16-1:0]  wdata = '0;
   logic [NP*2-1:0]   bytesel = '1;
   logic [NP-1:0]     ack;
   logic [15:0]       rdata;
   logic              ctrl_req;
   logic              ctrl_we;
   logic [AW-1:0]     ctrl_addr;
   logic [15:0]       ctrl_wdata;
   logic [1:0]        ctrl_bytesel;
   logic              ctrl_ack = 1'b0;
   logic              ctrl_done = 1'b0;
   logic [15:0]       ctrl_rdata = '0;
   logic              timeout_err;

   sdram_port_arbiter #(.NPORTS(NP), .AW(AW), .MAXRUN(MAXRUN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .bytesel(bytesel), .ack(ack), .rdata(rdata), .ctrl_req(ctrl_req),
      .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
      .ctrl_bytesel(ctrl_bytesel), .ctrl_ack(ctrl_ack), .ctrl_done(ctrl_done),
      .ctrl_rdata(ctrl_rdata), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // requester and controller behaviour knobs
   int rq_rem[NP];
   int rq_gap[NP];
   int rq_hold[NP];
   int bfm_ack_dly  = 0;
   int bfm_done_dly = 0;
   int bfm_phase    = 0;
   int bfm_cnt      = 0;
   logic [15:0] bfm_rdata = '0;
   logic        stray = 1'b0;

   // observations
   int          acked_q[$];
   int          last_ack_cyc = 0, last_done_cyc = 0, last_cack_cyc = 0;
   logic        prev_creq = 1'b0;
   logic        cap_we = 1'b0;
   logic [AW-1:0] cap_addr = '0;
   logic [15:0] cap_wdata = '0;
   logic [1:0]  cap_bs = '0;

   // model expected outputs
   logic [NP-1:0] e_ack = '0;
   logic [15:0]   e_rdata = '0;
   logic          e_req = 1'b0, e_we = 1'b0, e_terr = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [15:0]   e_wdata = '0;
   logic [1:0]    e_bs = 2'b11;
   int m_inflight = 0, m_accepted = 0, m_wait = 0, m_port = 0, m_run = 0, m_rr = 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model + per-cycle compare + monitor
   initial begin : model
      int p;
      int c;
      logic oth;
      logic [NP-1:0] nack;
      forever begin
         @(negedge clk);
         cyc++;
         chk("ack", 32'(ack), 32'(e_ack));
         chk("rdata", 32'(rdata), 32'(e_rdata));
         chk("ctrl_req", 32'(ctrl_req), 32'(e_req));
         chk("ctrl_we", 32'(ctrl_we), 32'(e_we));
         chk("ctrl_addr", 32'(ctrl_addr), 32'(e_addr));
         chk("ctrl_wdata", 32'(ctrl_wdata), 32'(e_wdata));
         chk("ctrl_bytesel", 32'(ctrl_bytesel), 32'(e_bs));
         chk("timeout_err", 32'(timeout_err), 32'(e_terr));
         for (int i = 0; i < NP; i++) if (ack[i] === 1'b1) begin
            acked_q.push_back(i);
            last_ack_cyc = cyc;
         end
         if (ctrl_done) last_done_cyc = cyc;
         if (ctrl_ack) last_cack_cyc = cyc;
         if (ctrl_req === 1'b1 && !prev_creq) begin
            cap_we = ctrl_we; cap_addr = ctrl_addr; cap_wdata = ctrl_wdata; cap_bs = ctrl_bytesel;
         end
         prev_creq = (ctrl_req === 1'b1);
         // advance the model by one clock using the inputs the DUT is about to sample
         nack = '0;
         if (reset) begin
            e_rdata = '0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            e_bs = 2'b11; e_terr = 1'b0;
            m_inflight = 0; m_accepted = 0; m_wait = 0; m_run = 0; m_rr = 1;
         end else if (m_inflight == 0) begin
            if (e_ack == '0 && req != '0) begin
               oth = (req[NP-1:1] != '0);
               p = -1;
               if (req[0] && (m_run < MAXRUN || !oth)) p = 0;
               else for (int k = 0; k < NP - 1; k++) begin
                  c = 1 + ((m_rr - 1 + k) % (NP - 1));
                  if (p < 0 && req[c]) p = c;
               end
               m_port = p;
               e_we = we[p]; e_addr = addr[p*AW +: AW];
               e_wdata = wdata[p*16 +: 16]; e_bs = bytesel[p*2 +: 2];
               e_req = 1'b1; m_inflight = 1; m_accepted = 0;
               if (p == 0) m_run = oth ? ((m_run + 1 > MAXRUN) ? MAXRUN : m_run + 1) : 0;
               else begin m_run = 0; m_rr = 1 + (p % (NP - 1)); end
            end
         end else if (m_accepted == 0) begin
            if (ctrl_ack) begin
               e_req = 1'b0;
               if (ctrl_done) begin
                  nack[m_port] = 1'b1; if (!e_we) e_rdata = ctrl_rdata; m_inflight = 0;
               end else begin
                  m_accepted = 1; m_wait = 0;
               end
            end
         end else begin
            if (ctrl_done) begin
               nack[m_port] = 1'b1; if (!e_we) e_rdata = ctrl_rdata; m_inflight = 0;
            end else begin
               m_wait++;
               if (m_wait == TIMEOUT) begin
                  nack[m_port] = 1'b1; e_rdata = '0; e_terr = 1'b1; m_inflight = 0;
               end
            end
         end
         e_ack = nack;
      end
   end

   // one clock of stimulus: requesters react to ack, controller BFM answers ctrl_req
   task automatic step();
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (ack[p] === 1'b1) begin
            if (rq_rem[p] > 0) rq_rem[p]--;
            if (rq_gap[p] == 0 && rq_rem[p] > 0) req[p] = 1'b1;
            else begin req[p] = 1'b0; rq_hold[p] = rq_gap[p] - 1; end
         end else if (!req[p] && rq_rem[p] > 0) begin
            if (rq_hold[p] > 0) rq_hold[p]--;
            else req[p] = 1'b1;
         end
      end
      ctrl_ack = 1'b0;
      ctrl_done = 1'b0;
      if (!reset) begin
         if (bfm_phase == 0 && ctrl_req === 1'b1) begin bfm_cnt = bfm_ack_dly; bfm_phase = 1; end
         if (bfm_phase == 1) begin
            if (bfm_cnt == 0) begin
               ctrl_ack = 1'b1;
               if (bfm_done_dly == 0) begin
                  ctrl_done = 1'b1; ctrl_rdata = bfm_rdata; bfm_phase = 0;
               end else begin
                  bfm_cnt = bfm_done_dly; bfm_phase = 2;
               end
            end else bfm_cnt--;
         end else if (bfm_phase == 2 && bfm_done_dly > 0) begin
            bfm_cnt--;
            if (bfm_cnt == 0) begin ctrl_done = 1'b1; ctrl_rdata = bfm_rdata; bfm_phase = 0; end
         end
      end
      if (stray) begin ctrl_done = 1'b1; ctrl_rdata = 16'h5555; stray = 1'b0; end
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [15:0] d, input logic [1:0] bs);
      we[p] = w; addr[p*AW +: AW] = a; wdata[p*16 +: 16] = d; bytesel[p*2 +: 2] = bs;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int p = 0; p < NP; p++) begin rq_rem[p] = 0; rq_hold[p] = 0; req[p] = 1'b0; end
      bfm_phase = 0;
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic run_until_quiet(input int maxc);
      int n;
      int left;
      n = 0;
      left = 1;
      while (n < maxc && left != 0) begin
         step();
         n++;
         left = 0;
         for (int p = 0; p < NP; p++) left += rq_rem[p];
         if (req != '0) left++;
      end
      if (left != 0) begin
         total++; bad++;
         $display("FAIL budget: %0d cycles elapsed, %0d requests outstanding", n, left);
      end
      repeat (3) step();
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int exp2[4];
      int exp3[10];
      int n0;
      exp2 = '{1, 2, 1, 2};
      exp3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int p = 0; p < NP; p++) begin rq_rem[p] = 0; rq_gap[p] = 1; rq_hold[p] = 0; end

      // reset state
      do_reset();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_creq", 32'(ctrl_req), 0);
      chk("rst_bytesel", 32'(ctrl_bytesel), 32'h3);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_terr", 32'(timeout_err), 0);

      // single read on port 1
      acked_q.delete();
      set_port(1, 1'b0, 24'h123456, 16'h0, 2'b11);
      bfm_ack_dly = 2; bfm_done_dly = 5; bfm_rdata = 16'hBEEF;
      rq_rem[1] = 1;
      run_until_quiet(100);
      chk("t1_nack", acked_q.size(), 1);
      if (acked_q.size() > 0) chk("t1_port", acked_q[0], 1);
      chk("t1_addr", 32'(cap_addr), 32'h123456);
      chk("t1_lat", last_ack_cyc - last_done_cyc, 1);
      chk("t1_rdata", 32'(rdata), 32'hBEEF);

      // write on port 2, rdata keeps the previous read
      acked_q.delete();
      set_port(2, 1'b1, 24'h00ABCD, 16'h1234, 2'b10);
      bfm_ack_dly = 1; bfm_done_dly = 2; bfm_rdata = 16'hDEAD;
      rq_rem[2] = 1;
      run_until_quiet(100);
      chk("t4_we", 32'(cap_we), 1);
      chk("t4_bs", 32'(cap_bs), 32'h2);
      chk("t4_wdata", 32'(cap_wdata), 32'h1234);
      chk("t4_nack", acked_q.size(), 1);
      chk("t4_rdata", 32'(rdata), 32'hBEEF);

      // ports 1 and 2 alternate round-robin
      do_reset();
      acked_q.delete();
      set_port(1, 1'b0, 24'h000100, 16'h0, 2'b11);
      set_port(2, 1'b0, 24'h000200, 16'h0, 2'b11);
      bfm_ack_dly = 0; bfm_done_dly = 0; bfm_rdata = 16'h0042;
      rq_gap[1] = 1; rq_gap[2] = 1; rq_rem[1] = 2; rq_rem[2] = 2;
      run_until_quiet(200);
      chk("t2_len", acked_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < acked_q.size()) chk($sformatf("t2_seq%0d", i), acked_q[i], exp2[i]);

      // port 0 capped at MAXRUN while port 1 waits
      do_reset();
      acked_q.delete();
      set_port(0, 1'b0, 24'h000010, 16'h0, 2'b11);
      bfm_ack_dly = 0; bfm_done_dly = 1; bfm_rdata = 16'h0077;
      rq_gap[0] = 0; rq_gap[1] = 0; rq_rem[0] = 8; rq_rem[1] = 2;
      run_until_quiet(300);
      chk("t3_len", acked_q.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < acked_q.size()) chk($sformatf("t3_seq%0d", i), acked_q[i], exp3[i]);
      rq_gap[0] = 1; rq_gap[1] = 1;

      // timeout: a normal read first so rdata is nonzero, then done withheld
      do_reset();
      bfm_ack_dly = 0; bfm_done_dly = 1; bfm_rdata = 16'hA5A5;
      rq_rem[1] = 1;
      run_until_quiet(50);
      chk("t5_pre_rdata", 32'(rdata), 32'hA5A5);
      acked_q.delete();
      bfm_done_dly = -1;
      rq_rem[1] = 1;
      run_until_quiet(400);
      chk("t5_nack", acked_q.size(), 1);
      chk("t5_delay", last_ack_cyc - last_cack_cyc, TIMEOUT + 1);
      chk("t5_rdata", 32'(rdata), 0);
      chk("t5_terr", 32'(timeout_err), 1);
      bfm_phase = 0;
      stray = 1'b1;
      repeat (4) step();
      chk("t5_stray_nack", acked_q.size(), 1);
      chk("t5_stray_rdata", 32'(rdata), 0);
      chk("t5_terr_sticky", 32'(timeout_err), 1);

      // reset while waiting for ctrl_done
      acked_q.delete();
      rq_rem[1] = 1;
      repeat (10) step();
      n0 = acked_q.size();
      do_reset();
      repeat (2) step();
      chk("t6_noack", acked_q.size(), n0);
      chk("t6_creq", 32'(ctrl_req), 0);
      chk("t6_terr", 32'(timeout_err), 0);
      chk("t6_bs", 32'(ctrl_bytesel), 32'h3);
      acked_q.delete();
      set_port(2, 1'b0, 24'h0000F0, 16'h0, 2'b01);
      bfm_ack_dly = 0; bfm_done_dly = 1; bfm_rdata = 16'h0F0F;
      rq_rem[2] = 1;
      run_until_quiet(50);
      chk("t6_nack", acked_q.size(), 1);
      if (acked_q.size() > 0) chk("t6_port", acked_q[0], 2);
      chk("t6_rdata", 32'(rdata), 32'h0F0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
